huffman_encoder: RTL and testbench
==================================

Name: huffman_encoder

Overview:
- Upstream stage to the Huffman decoder.
- Accepts one 5-bit symbol index per handshake, looks it up in a fixed canonical Huffman codebook of 18 symbols, and serializes the codeword MSB-first on a 1-bit valid/ready stream.
- Produces the serial bitstream the decoder consumes. Also keeps an encoded-symbol counter and flags illegal symbol indices.

Parameters:
- SYM_W, 5, width of the symbol index.
- NUM_SYM, 18, number of legal symbols (indices 0..17).
- MAX_LEN, 7, longest codeword length in bits; sizes the shift register and bit counter.
- CNT_W, 16, width of the encoded-symbol counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sym_valid  input  1  upstream symbol valid.
- sym_in  input  SYM_W  symbol index.
- sym_ready  output  1  encoder can accept a symbol.
- bit_out  output  1  serial codeword bit, MSB first.
- bit_valid  output  1  bit_out valid.
- bit_last  output  1  bit_out is the final bit of the current codeword.
- bit_ready  input  1  downstream accepts bit.
- sym_err  output  1  one-cycle pulse: illegal index accepted.
- sym_count  output  CNT_W  number of legal symbols fully emitted.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Decided; not configurable.
- Codebook (index: code), canonical, lengths 2/3/4/6/7:
  - 0: 00
  - 1: 010, 2: 011, 3: 100
  - 4: 1010, 5: 1011, 6: 1100, 7: 1101
  - 8: 111000, 9: 111001, 10: 111010, 11: 111011, 12: 111100, 13: 111101
  - 14: 1111100, 15: 1111101, 16: 1111110, 17: 1111111
- State machine:
  - IDLE: sym_ready=1, bit_valid=0.
  - On sym_valid && sym_in<NUM_SYM: load code left-aligned into shift register, load length into bit counter, go to SHIFT.
  - On sym_valid && sym_in>=NUM_SYM: consume the symbol, pulse sym_err for 1 cycle, stay IDLE, emit no bits.
  - SHIFT: sym_ready=0, bit_valid=1, bit_out=shift MSB. On bit_valid&&bit_ready, shift left one and decrement the counter.
  - bit_last=1 when the counter equals 1. On the handshake of that last bit, go to IDLE and increment sym_count (wraps modulo 2^CNT_W).
- Latency: symbol accepted at edge N; first bit valid in cycle N+1. Minimum one IDLE cycle between codewords, so sym_ready is never high in SHIFT.
- Stall: while bit_valid && !bit_ready, bit_out, bit_last and all internal state hold stable.
- Reset (including mid-codeword): state=IDLE, bit_out=0, bit_valid=0, bit_last=0, sym_err=0, sym_count=0. Any partial codeword is discarded.
- sym_ready after reset: 0 during the reset cycle, 1 from the next cycle.

Optional Feature:
- Macro: HUFF_ENC_PREAMBLE_EN.
- Defined: each legal codeword is preceded by start marker bits 0 then 1.
  - Adds state PREAMBLE, entered from IDLE on accept, before SHIFT.
  - Marker bits obey the same valid/ready stall rules; bit_last=0 on marker bits.
  - First codeword bit appears 2 handshakes later than without the feature.
- Not defined: PREAMBLE state absent; only codeword bits are emitted.

Test Plan:
- Reset, then symbol 0 with bit_ready=1 held: sym_ready drops; bits 0,0 in consecutive cycles, bit_last on the 2nd; sym_count=1; sym_ready=1 the next cycle.
- Symbols 3, 17, 8 back-to-back with bit_ready=1: stream 100 / 1111111 / 111000; bit_last on bits 3, 10, 16; one idle cycle between codewords; sym_count=3.
- Symbol 13 with bit_ready toggling 1,0,0,1,…: exactly 6 handshakes yielding 111101; bit_out/bit_last stable during every stall cycle.
- sym_in=18, then 31: each accepted with sym_ready=1; one-cycle sym_err pulse each; bit_valid stays 0; sym_count unchanged.
- Reset asserted after 3 of 7 bits of symbol 15: next cycle bit_valid=0, sym_count=0; a new symbol 1 then produces 010 cleanly.
- With HUFF_ENC_PREAMBLE_EN, symbol 5: stream 0,1,1,0,1,1; bit_last only on the 6th bit; sym_count=1.

Source files
------------

// File: rtl/huffman_encoder.sv
// huffman_encoder: looks up a 5-bit symbol index in a fixed 18-entry canonical
// Huffman codebook and serializes the codeword MSB-first on a 1-bit
// valid/ready stream. Illegal indices are consumed and flagged with sym_err.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   sym_valid  upstream symbol valid
//   sym_in     symbol index
//   sym_ready  encoder can accept a symbol (IDLE and not in reset)
//   bit_out    serial codeword bit, MSB first
//   bit_valid  bit_out valid
//   bit_last   bit_out is the final bit of the current codeword
//   bit_ready  downstream accepts bit
//   sym_err    one-cycle pulse when an illegal index is accepted
//   sym_count  number of legal symbols fully emitted (wraps)
//
// Optional feature macro: HUFF_ENC_PREAMBLE_EN -- when defined, each legal
// codeword is preceded by the marker bits 0 then 1 (never flagged bit_last).
module huffman_encoder #(
  parameter int unsigned SYM_W   = 5,
  parameter int unsigned NUM_SYM = 18,
  parameter int unsigned MAX_LEN = 7,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_in,
  output logic             sym_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  input  logic             bit_ready,
  output logic             sym_err,
  output logic [CNT_W-1:0] sym_count
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

`ifdef HUFF_ENC_PREAMBLE_EN
  typedef enum logic [1:0] {StIdle, StShift, StPreamble} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e             state_q;
  logic [MAX_LEN-1:0] shift_q;
  logic [LenW-1:0]    cnt_q;
  logic               bit_out_q;
  logic               bit_valid_q;
  logic               bit_last_q;
  logic               sym_err_q;
  logic [CNT_W-1:0]   sym_count_q;
`ifdef HUFF_ENC_PREAMBLE_EN
  logic               mark_q;  // 0: first marker bit on the wire, 1: second
`endif

  // Codebook lookup, codes left-aligned in MAX_LEN bits.
  logic [MAX_LEN-1:0] lut_code;
  logic [LenW-1:0]    lut_len;
  logic               sym_legal;

  always_comb begin
    lut_code = '0;
    lut_len  = '0;
    unique case (32'(sym_in))
      0:  begin lut_code = 7'b0000000; lut_len = LenW'(2); end
      1:  begin lut_code = 7'b0100000; lut_len = LenW'(3); end
      2:  begin lut_code = 7'b0110000; lut_len = LenW'(3); end
      3:  begin lut_code = 7'b1000000; lut_len = LenW'(3); end
      4:  begin lut_code = 7'b1010000; lut_len = LenW'(4); end
      5:  begin lut_code = 7'b1011000; lut_len = LenW'(4); end
      6:  begin lut_code = 7'b1100000; lut_len = LenW'(4); end
      7:  begin lut_code = 7'b1101000; lut_len = LenW'(4); end
      8:  begin lut_code = 7'b1110000; lut_len = LenW'(6); end
      9:  begin lut_code = 7'b1110010; lut_len = LenW'(6); end
      10: begin lut_code = 7'b1110100; lut_len = LenW'(6); end
      11: begin lut_code = 7'b1110110; lut_len = LenW'(6); end
      12: begin lut_code = 7'b1111000; lut_len = LenW'(6); end
      13: begin lut_code = 7'b1111010; lut_len = LenW'(6); end
      14: begin lut_code = 7'b1111100; lut_len = LenW'(7); end
      15: begin lut_code = 7'b1111101; lut_len = LenW'(7); end
      16: begin lut_code = 7'b1111110; lut_len = LenW'(7); end
      17: begin lut_code = 7'b1111111; lut_len = LenW'(7); end
      default: begin lut_code = '0; lut_len = '0; end
    endcase
  end

  assign sym_legal = 32'(sym_in) < NUM_SYM;

  // Held low during the reset cycle even if the FSM was mid-codeword.
  assign sym_ready = (state_q == StIdle) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      sym_err_q   <= 1'b0;
      sym_count_q <= '0;
`ifdef HUFF_ENC_PREAMBLE_EN
      mark_q      <= 1'b0;
`endif
    end else begin
      sym_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sym_valid) begin
            if (sym_legal) begin
              shift_q     <= lut_code;
              cnt_q       <= lut_len;
              bit_valid_q <= 1'b1;
`ifdef HUFF_ENC_PREAMBLE_EN
              state_q     <= StPreamble;
              mark_q      <= 1'b0;
              bit_out_q   <= 1'b0;
              bit_last_q  <= 1'b0;
`else
              state_q     <= StShift;
              bit_out_q   <= lut_code[MAX_LEN-1];
              bit_last_q  <= (lut_len == LenW'(1));
`endif
            end else begin
              sym_err_q <= 1'b1;
            end
          end
        end
`ifdef HUFF_ENC_PREAMBLE_EN
        StPreamble: begin
          if (bit_ready) begin
            if (!mark_q) begin
              mark_q    <= 1'b1;
              bit_out_q <= 1'b1;
            end else begin
              state_q    <= StShift;
              bit_out_q  <= shift_q[MAX_LEN-1];
              bit_last_q <= (cnt_q == LenW'(1));
            end
          end
        end
`endif
        StShift: begin
          if (bit_ready) begin
            if (cnt_q == LenW'(1)) begin
              state_q     <= StIdle;
              bit_valid_q <= 1'b0;
              bit_out_q   <= 1'b0;
              bit_last_q  <= 1'b0;
              sym_count_q <= sym_count_q + CNT_W'(1);
            end else begin
              shift_q    <= shift_q << 1;
              cnt_q      <= cnt_q - LenW'(1);
              // Present the bit that becomes MSB after this shift.
              bit_out_q  <= shift_q[MAX_LEN-2];
              bit_last_q <= (cnt_q == LenW'(2));
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign bit_last  = bit_last_q;
  assign sym_err   = sym_err_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed self-checking bench for huffman_encoder. Inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_huffman_encoder;

  logic        clk;
  logic        reset;
  logic        sym_valid;
  logic [4:0]  sym_in;
  logic        sym_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_last;
  logic        bit_ready;
  logic        sym_err;
  logic [15:0] sym_count;

  int errors = 0;
  int checks = 0;

`ifdef HUFF_ENC_PREAMBLE_EN
  localparam int Pre = 2;
`else
  localparam int Pre = 0;
`endif

  huffman_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .sym_valid (sym_valid),
    .sym_in    (sym_in),
    .sym_ready (sym_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .bit_ready (bit_ready),
    .sym_err   (sym_err),
    .sym_count (sym_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one symbol for exactly one accepting edge.
  task automatic send(input logic [4:0] s);
    sym_valid = 1'b1;
    sym_in    = s;
    step();
    sym_valid = 1'b0;
  endtask

  // Expected stream bit i for a right-aligned code of length len.
  function automatic logic exp_bit(input logic [6:0] code, input int len, input int i);
    if (i < Pre) return (i == 1);
    return code[len - 1 - (i - Pre)];
  endfunction

  // Check up to 'limit' stream bits with bit_ready held high.
  task automatic run_bits(input string tag, input logic [6:0] code, input int len,
                          input int limit);
    int tot;
    tot = len + Pre;
    bit_ready = 1'b1;
    for (int i = 0; i < tot && i < limit; i++) begin
      chk({tag, "_valid"}, 32'(bit_valid), 32'd1);
      chk({tag, "_ready"}, 32'(sym_ready), 32'd0);
      chk({tag, "_bit"}, 32'(bit_out), 32'(exp_bit(code, len, i)));
      chk({tag, "_last"}, 32'(bit_last), 32'(i == tot - 1));
      step();
    end
  endtask

  initial begin
    logic [3:0] pat;
    int hs;
    reset     = 1'b1;
    sym_valid = 1'b0;
    sym_in    = '0;
    bit_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_ready", 32'(sym_ready), 32'd0);
    chk("rst_valid", 32'(bit_valid), 32'd0);
    chk("rst_last", 32'(bit_last), 32'd0);
    chk("rst_err", 32'(sym_err), 32'd0);
    chk("rst_count", 32'(sym_count), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(sym_ready), 32'd1);

    // Symbol 0 -> 00
    send(5'd0);
    run_bits("s0", 7'b00, 2, 99);
    chk("s0_idle_valid", 32'(bit_valid), 32'd0);
    chk("s0_idle_ready", 32'(sym_ready), 32'd1);
    chk("s0_count", 32'(sym_count), 32'd1);

    // Back-to-back 3, 17, 8 with one idle cycle between codewords
    send(5'd3);
    run_bits("s3", 7'b100, 3, 99);
    chk("s3_gap_ready", 32'(sym_ready), 32'd1);
    chk("s3_gap_valid", 32'(bit_valid), 32'd0);
    send(5'd17);
    run_bits("s17", 7'b1111111, 7, 99);
    chk("s17_gap_ready", 32'(sym_ready), 32'd1);
    send(5'd8);
    run_bits("s8", 7'b111000, 6, 99);
    chk("b2b_count", 32'(sym_count), 32'd4);

    // Symbol 13 with bit_ready pattern 1,0,0,1 repeating
    pat = 4'b1001;
    send(5'd13);
    hs = 0;
    for (int c = 0; c < 60 && hs < 6 + Pre; c++) begin
      bit_ready = pat[c % 4];
      chk("s13_valid", 32'(bit_valid), 32'd1);
      chk("s13_bit", 32'(bit_out), 32'(exp_bit(7'b111101, 6, hs)));
      chk("s13_last", 32'(bit_last), 32'(hs == 5 + Pre));
      if (bit_ready) hs++;
      step();
    end
    chk("s13_handshakes", 32'(hs), 32'(6 + Pre));
    chk("s13_done_valid", 32'(bit_valid), 32'd0);
    chk("s13_count", 32'(sym_count), 32'd5);
    bit_ready = 1'b1;

    // Illegal indices 18 and 31
    sym_valid = 1'b1;
    sym_in    = 5'd18;
    #1;
    chk("ill18_ready", 32'(sym_ready), 32'd1);
    step();
    sym_valid = 1'b0;
    chk("ill18_err", 32'(sym_err), 32'd1);
    chk("ill18_valid", 32'(bit_valid), 32'd0);
    step();
    chk("ill18_err_drop", 32'(sym_err), 32'd0);
    chk("ill18_ready2", 32'(sym_ready), 32'd1);
    send(5'd31);
    chk("ill31_err", 32'(sym_err), 32'd1);
    chk("ill31_valid", 32'(bit_valid), 32'd0);
    step();
    chk("ill31_err_drop", 32'(sym_err), 32'd0);
    chk("ill31_valid2", 32'(bit_valid), 32'd0);
    chk("ill_count", 32'(sym_count), 32'd5);

    // Reset after 3 of 7 bits of symbol 15
    send(5'd15);
    run_bits("s15", 7'b1111101, 7, 3);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(bit_valid), 32'd0);
    chk("mid_rst_last", 32'(bit_last), 32'd0);
    chk("mid_rst_count", 32'(sym_count), 32'd0);
    chk("mid_rst_ready", 32'(sym_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready2", 32'(sym_ready), 32'd1);
    send(5'd1);
    run_bits("s1", 7'b010, 3, 99);
    chk("s1_count", 32'(sym_count), 32'd1);
    chk("s1_ready", 32'(sym_ready), 32'd1);

`ifdef HUFF_ENC_PREAMBLE_EN
    // Symbol 5 with markers -> 0,1,1,0,1,1
    send(5'd5);
    run_bits("s5", 7'b1011, 4, 99);
    chk("s5_count", 32'(sym_count), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
